// File: rtl/pcie_cfg_pkg.sv
// Shared definitions for the PCIe configuration completion tracker:
// completion status codes, RC descriptor field positions and helpers.
package pcie_cfg_pkg;

  typedef enum logic [2:0] {
    CPL_SC  = 3'b000,
    CPL_UR  = 3'b001,
    CPL_CRS = 3'b010,
    CPL_CA  = 3'b100
  } cpl_status_e;

  localparam int unsigned FMT_BIT    = 30;
  localparam int unsigned STATUS_LSB = 43;
  localparam int unsigned TAG_LSB    = 64;
  localparam int unsigned REQ_ID_LSB = 72;
  localparam int unsigned DATA_LSB   = 96;
  localparam int unsigned SOP_BIT    = 32;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pcie_cfg_tag_timer.sv
// Per-tag timeout counter: loads on issue, counts down once per cycle and
// holds at zero, where it reports expiry.
module pcie_cfg_tag_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic user_clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT_CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pcie_cfg_cpl_tracker.sv
// Tracks outstanding PCIe configuration requests by tag, matches completions
// on the RC stream, reports results/timeouts and forwards the stream.
module pcie_cfg_cpl_tracker
  import pcie_cfg_pkg::*;
#(
  parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
  parameter int unsigned AXI4_RC_TUSER_WIDTH = 75,
  parameter int unsigned C_DATA_WIDTH        = 128,
  parameter int unsigned KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int unsigned NUM_TAGS            = 4,
  parameter int unsigned TIMEOUT_CYCLES      = 50000,
  parameter int unsigned EXTRA_PIPELINE      = 1
) (
  input  logic                           user_clk,
  input  logic                           reset_n,
  input  logic [C_DATA_WIDTH-1:0]        rport_m_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0]          rport_m_axis_rc_tkeep,
  input  logic                           rport_m_axis_rc_tlast,
  input  logic                           rport_m_axis_rc_tvalid,
  input  logic [AXI4_RC_TUSER_WIDTH-1:0] rport_m_axis_rc_tuser,
  output logic                           rport_m_axis_rc_tready,
  output logic [C_DATA_WIDTH-1:0]        usr_m_axis_rc_tdata,
  output logic [KEEP_WIDTH-1:0]          usr_m_axis_rc_tkeep,
  output logic                           usr_m_axis_rc_tlast,
  output logic                           usr_m_axis_rc_tvalid,
  output logic [AXI4_RC_TUSER_WIDTH-1:0] usr_m_axis_rc_tuser,
  input  logic                           config_mode,
  input  logic                           icq_full,
  input  logic                           req_valid,
  input  logic [2:0]                     req_tag,
  output logic                           req_err,
  output logic                           res_valid,
  output logic [2:0]                     res_tag,
  output logic                           res_sc,
  output logic                           res_ur,
  output logic                           res_crs,
  output logic                           res_ca,
  output logic                           res_timeout,
  output logic [31:0]                    res_data,
  output logic                           cpl_mismatch,
  output logic [3:0]                     outstanding
);

  localparam logic [7:0] TAG_LIMIT8 = 8'(NUM_TAGS);
  localparam logic [3:0] TAG_LIMIT4 = 4'(NUM_TAGS);

  logic                           accept;
  logic                           chk_valid;
  logic [C_DATA_WIDTH-1:0]        chk_data;
  logic [KEEP_WIDTH-1:0]          chk_keep;
  logic                           chk_last;
  logic [AXI4_RC_TUSER_WIDTH-1:0] chk_user;

  assign rport_m_axis_rc_tready = ~icq_full;
  assign accept = rport_m_axis_rc_tvalid & ~icq_full;

  if (EXTRA_PIPELINE != 0) begin : g_chk_reg
    always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) begin
        chk_valid <= 1'b0;
        chk_data  <= '0;
        chk_keep  <= '0;
        chk_last  <= 1'b0;
        chk_user  <= '0;
      end else begin
        chk_valid <= accept;
        chk_data  <= rport_m_axis_rc_tdata;
        chk_keep  <= rport_m_axis_rc_tkeep;
        chk_last  <= rport_m_axis_rc_tlast;
        chk_user  <= rport_m_axis_rc_tuser;
      end
    end
  end else begin : g_chk_bypass
    assign chk_valid = accept;
    assign chk_data  = rport_m_axis_rc_tdata;
    assign chk_keep  = rport_m_axis_rc_tkeep;
    assign chk_last  = rport_m_axis_rc_tlast;
    assign chk_user  = rport_m_axis_rc_tuser;
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      usr_m_axis_rc_tvalid <= 1'b0;
      usr_m_axis_rc_tdata  <= '0;
      usr_m_axis_rc_tkeep  <= '0;
      usr_m_axis_rc_tlast  <= 1'b0;
      usr_m_axis_rc_tuser  <= '0;
    end else begin
      usr_m_axis_rc_tvalid <= chk_valid & ~config_mode;
      usr_m_axis_rc_tdata  <= chk_data;
      usr_m_axis_rc_tkeep  <= chk_keep;
      usr_m_axis_rc_tlast  <= chk_last;
      usr_m_axis_rc_tuser  <= chk_user;
    end
  end

  // Tag vectors are fixed at 8 bits so the 3-bit tag indexes them directly;
  // bits at or above NUM_TAGS can never be set.
  logic [7:0] busy, busy_next, set_vec, clr_vec, tmr_exp, exp_vec;
  logic       is_cpl, cpl_hit, issue_ok, exp_any, found;
  logic [7:0] cpl_tag;
  logic [2:0] cpl_status, exp_idx;

  for (genvar i = 0; i < 8; i++) begin : g_tag
    if (i < NUM_TAGS) begin : g_tmr
      pcie_cfg_tag_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_tmr (
        .user_clk(user_clk),
        .reset_n (reset_n),
        .load    (set_vec[i]),
        .expired (tmr_exp[i])
      );
    end else begin : g_none
      assign tmr_exp[i] = 1'b0;
    end
  end

  always_comb begin
    is_cpl     = chk_valid & chk_user[SOP_BIT] & chk_data[FMT_BIT];
    cpl_tag    = chk_data[TAG_LSB +: 8];
    cpl_status = chk_data[STATUS_LSB +: 3];
    cpl_hit    = is_cpl && (chk_data[REQ_ID_LSB +: 16] == REQUESTER_ID) &&
                 (cpl_tag < TAG_LIMIT8) && busy[cpl_tag[2:0]];
    issue_ok   = req_valid && ({1'b0, req_tag} < TAG_LIMIT4) && !busy[req_tag];

    exp_vec = busy & tmr_exp;
    exp_any = |exp_vec;
    exp_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (exp_vec[i] && !found) begin
        exp_idx = 3'(i);
        found   = 1'b1;
      end
    end

    // Completion outranks expiry; an expired tag left unreported stays busy
    // with its timer parked at zero, so it reports on a later cycle.
    set_vec = issue_ok ? (8'b1 << req_tag) : '0;
    if (cpl_hit)      clr_vec = 8'b1 << cpl_tag[2:0];
    else if (exp_any) clr_vec = 8'b1 << exp_idx;
    else              clr_vec = '0;
    busy_next = (busy & ~clr_vec) | set_vec;
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      outstanding  <= '0;
      req_err      <= 1'b0;
      cpl_mismatch <= 1'b0;
      res_valid    <= 1'b0;
      res_tag      <= '0;
      res_sc       <= 1'b0;
      res_ur       <= 1'b0;
      res_crs      <= 1'b0;
      res_ca       <= 1'b0;
      res_timeout  <= 1'b0;
      res_data     <= '0;
    end else begin
      busy         <= busy_next;
      outstanding  <= popcount8(busy_next);
      req_err      <= req_valid & ~issue_ok;
      cpl_mismatch <= is_cpl & ~cpl_hit;
      res_valid    <= cpl_hit | exp_any;
      res_tag      <= cpl_hit ? cpl_tag[2:0] : exp_idx;
      res_sc       <= cpl_hit && (cpl_status == CPL_SC);
      res_ur       <= cpl_hit && (cpl_status == CPL_UR);
      res_crs      <= cpl_hit && (cpl_status == CPL_CRS);
      res_ca       <= cpl_hit && (cpl_status == CPL_CA);
      res_timeout  <= ~cpl_hit & exp_any;
      res_data     <= (cpl_hit && chk_keep[3]) ? chk_data[DATA_LSB +: 32] : '0;
    end
  end

endmodule

// File: tb/tb_pcie_cfg_cpl_tracker.sv
// Bench for pcie_cfg_cpl_tracker: directed scenarios plus random traffic,
// checked every cycle against a deadline-based reference model.
module tb_pcie_cfg_cpl_tracker;

  localparam int          T      = 16;
  localparam logic [15:0] REQ_ID = 16'h10EE;

  logic         user_clk = 1'b0;
  logic         reset_n  = 1'b1;
  logic [127:0] rc_tdata;
  logic [3:0]   rc_tkeep;
  logic         rc_tlast, rc_tvalid, rc_tready;
  logic [74:0]  rc_tuser;
  logic [127:0] usr_tdata;
  logic [3:0]   usr_tkeep;
  logic         usr_tlast, usr_tvalid;
  logic [74:0]  usr_tuser;
  logic         config_mode, icq_full, req_valid, req_err;
  logic [2:0]   req_tag, res_tag;
  logic         res_valid, res_sc, res_ur, res_crs, res_ca, res_timeout, cpl_mismatch;
  logic [31:0]  res_data;
  logic [3:0]   outstanding;

  always #5 user_clk = ~user_clk;

  pcie_cfg_cpl_tracker #(
    .REQUESTER_ID  (REQ_ID),
    .C_DATA_WIDTH  (128),
    .NUM_TAGS      (4),
    .TIMEOUT_CYCLES(T),
    .EXTRA_PIPELINE(1)
  ) dut (
    .user_clk              (user_clk),
    .reset_n               (reset_n),
    .rport_m_axis_rc_tdata (rc_tdata),
    .rport_m_axis_rc_tkeep (rc_tkeep),
    .rport_m_axis_rc_tlast (rc_tlast),
    .rport_m_axis_rc_tvalid(rc_tvalid),
    .rport_m_axis_rc_tuser (rc_tuser),
    .rport_m_axis_rc_tready(rc_tready),
    .usr_m_axis_rc_tdata   (usr_tdata),
    .usr_m_axis_rc_tkeep   (usr_tkeep),
    .usr_m_axis_rc_tlast   (usr_tlast),
    .usr_m_axis_rc_tvalid  (usr_tvalid),
    .usr_m_axis_rc_tuser   (usr_tuser),
    .config_mode           (config_mode),
    .icq_full              (icq_full),
    .req_valid             (req_valid),
    .req_tag               (req_tag),
    .req_err               (req_err),
    .res_valid             (res_valid),
    .res_tag               (res_tag),
    .res_sc                (res_sc),
    .res_ur                (res_ur),
    .res_crs               (res_crs),
    .res_ca                (res_ca),
    .res_timeout           (res_timeout),
    .res_data              (res_data),
    .cpl_mismatch          (cpl_mismatch),
    .outstanding           (outstanding)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a tag is busy until completed or reported; it becomes
  // reportable as a timeout from its deadline edge onwards.
  typedef struct packed {
    logic         v;
    logic [127:0] d;
    logic [3:0]   k;
    logic [74:0]  u;
  } beat_t;

  bit          mbusy[8];
  int          deadline[8];
  int          cyc;
  beat_t       pipe;
  logic [40:0] e_res;
  bit          e_mis, e_err, e_usr_v;
  logic [31:0] e_usr_d;
  int          e_out;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mbusy[i]    = 1'b0;
      deadline[i] = 0;
    end
    pipe = '0;
  endtask

  task automatic model_edge();
    logic [7:0] t;
    logic [4:0] oh;
    bit         cpl, hit;
    int         et;
    cyc++;
    cpl = pipe.v && pipe.u[32] && pipe.d[30];
    t   = pipe.d[71:64];
    hit = cpl && (pipe.d[87:72] == REQ_ID) && (t < 8'd4) && mbusy[t[2:0]];
    e_mis = cpl && !hit;
    e_err = req_valid && ((req_tag >= 3'd4) || mbusy[req_tag]);
    et = -1;
    for (int i = 0; i < 4; i++)
      if (et < 0 && mbusy[i] && cyc >= deadline[i]) et = i;
    e_res = '0;
    if (hit) begin
      case (pipe.d[45:43])
        3'b000:  oh = 5'b10000;
        3'b001:  oh = 5'b01000;
        3'b010:  oh = 5'b00100;
        3'b100:  oh = 5'b00010;
        default: oh = 5'b00000;
      endcase
      e_res = {1'b1, t[2:0], oh, pipe.k[3] ? pipe.d[127:96] : 32'h0};
      mbusy[t[2:0]] = 1'b0;
    end else if (et >= 0) begin
      e_res = {1'b1, 3'(et), 5'b00001, 32'h0};
      mbusy[et] = 1'b0;
    end
    if (req_valid && !e_err) begin
      mbusy[req_tag]    = 1'b1;
      deadline[req_tag] = cyc + T + 1;
    end
    e_usr_v = pipe.v && !config_mode;
    e_usr_d = pipe.d[127:96];
    e_out = 0;
    for (int i = 0; i < 8; i++) e_out += int'(mbusy[i]);
    pipe.v = rc_tvalid && !icq_full;
    pipe.d = rc_tdata;
    pipe.k = rc_tkeep;
    pipe.u = rc_tuser;
  endtask

  task automatic compare_all();
    check("res", 64'({res_valid, res_tag, res_sc, res_ur, res_crs, res_ca, res_timeout, res_data}), 64'(e_res));
    check("cpl_mismatch", 64'(cpl_mismatch), 64'(e_mis));
    check("req_err", 64'(req_err), 64'(e_err));
    check("outstanding", 64'(outstanding), 64'(e_out));
    check("usr_tvalid", 64'(usr_tvalid), 64'(e_usr_v));
    if (e_usr_v) check("usr_tdata", 64'(usr_tdata[127:96]), 64'(e_usr_d));
    check("tready", 64'(rc_tready), 64'(!icq_full));
  endtask

  task automatic step();
    @(posedge user_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_tag   = '0;
    rc_tvalid = 1'b0;
    rc_tdata  = '0;
    rc_tkeep  = '0;
    rc_tlast  = 1'b0;
    rc_tuser  = '0;
  endtask

  task automatic issue(input logic [2:0] tag);
    idle();
    req_valid = 1'b1;
    req_tag   = tag;
    step();
    req_valid = 1'b0;
  endtask

  task automatic cpl_beat(input logic [7:0] tag, input logic [15:0] id, input logic [2:0] st,
                          input logic [31:0] data, input bit keep3);
    idle();
    rc_tvalid        = 1'b1;
    rc_tdata[30]     = 1'b1;
    rc_tdata[87:72]  = id;
    rc_tdata[71:64]  = tag;
    rc_tdata[45:43]  = st;
    rc_tdata[127:96] = data;
    rc_tkeep         = keep3 ? 4'hF : 4'h7;
    rc_tlast         = 1'b1;
    rc_tuser[32]     = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #1;
    check("rst_res", 64'({res_valid, res_tag, res_sc, res_ur, res_crs, res_ca, res_timeout, res_data}), 64'h0);
    check("rst_flags", 64'({cpl_mismatch, req_err, usr_tvalid}), 64'h0);
    check("rst_outstanding", 64'(outstanding), 64'h0);
    repeat (2) @(posedge user_clk);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_inputs();
    req_valid        = ($urandom_range(0, 4) == 0);
    req_tag          = 3'($urandom_range(0, 5));
    rc_tvalid        = ($urandom_range(0, 2) == 0);
    rc_tdata         = {$urandom, $urandom, $urandom, $urandom};
    rc_tdata[30]     = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 4) != 0) rc_tdata[87:72] = REQ_ID;
    rc_tdata[71:64]  = 8'($urandom_range(0, 5));
    rc_tkeep         = 4'($urandom);
    rc_tlast         = 1'($urandom);
    rc_tuser         = {11'($urandom), $urandom, $urandom};
    rc_tuser[32]     = ($urandom_range(0, 2) != 0);
    icq_full         = ($urandom_range(0, 9) == 0);
    config_mode      = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    cyc = 0;
    config_mode = 1'b0;
    icq_full    = 1'b0;
    idle();
    model_reset();
    #2;
    do_reset();

    // Basic completion on tag 2
    issue(3'd2);
    step();
    cpl_beat(8'd2, REQ_ID, 3'b000, 32'hCAFE0001, 1'b1);
    step();
    idle();
    repeat (3) step();

    // Timeout on tag 1
    issue(3'd1);
    repeat (T + 4) step();

    // Wrong requester ID, then a valid UR completion
    issue(3'd0);
    cpl_beat(8'd0, 16'h1234, 3'b000, 32'h11111111, 1'b1);
    step();
    idle();
    repeat (3) step();
    cpl_beat(8'd0, REQ_ID, 3'b001, 32'h22222222, 1'b0);
    step();
    idle();
    repeat (3) step();

    // Completions colliding with expiries; expiries deferred in tag order
    issue(3'd0);
    issue(3'd3);
    issue(3'd1);
    issue(3'd2);
    repeat (12) step();
    cpl_beat(8'd2, REQ_ID, 3'b010, 32'h33333333, 1'b1);
    step();
    cpl_beat(8'd1, REQ_ID, 3'b100, 32'h44444444, 1'b1);
    step();
    idle();
    repeat (6) step();

    // Double issue, backpressure and config mode
    issue(3'd2);
    issue(3'd2);
    issue(3'd6);
    icq_full = 1'b1;
    cpl_beat(8'd2, REQ_ID, 3'b000, 32'h55555555, 1'b1);
    step();
    icq_full = 1'b0;
    idle();
    repeat (2) step();
    config_mode = 1'b1;
    cpl_beat(8'd2, REQ_ID, 3'b000, 32'h66666666, 1'b1);
    step();
    idle();
    repeat (2) step();
    config_mode = 1'b0;
    repeat (2) step();

    // Reset with three tags busy
    issue(3'd0);
    issue(3'd1);
    issue(3'd2);
    step();
    do_reset();
    repeat (T + 8) step();

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      rand_inputs();
      step();
    end
    config_mode = 1'b0;
    icq_full    = 1'b0;
    idle();
    repeat (T + 10) step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_cfg_cpl_tracker.md
PCIE_CFG_CPL_TRACKER -- requirements
Module: pcie_cfg_cpl_tracker

Interface
REQ-001 Parameters SHALL be: REQUESTER_ID 16'h10EE, 16-bit ID matched against descriptor bits [87:72].
REQ-002 AXI4_RC_TUSER_WIDTH 75 (RC tuser width); C_DATA_WIDTH 128 (128 or 256 only); KEEP_WIDTH C_DATA_WIDTH/32.
REQ-003 NUM_TAGS 4 (outstanding config requests, 1..8); TIMEOUT_CYCLES 50000 (per-tag timeout, 2..2^20); EXTRA_PIPELINE 1 (0 or 1).
REQ-004 Ports SHALL be: user_clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-005 rport_m_axis_rc_tdata/tkeep/tlast/tvalid/tuser in C_DATA_WIDTH/KEEP_WIDTH/1/1/AXI4_RC_TUSER_WIDTH: RC stream from root port; rport_m_axis_rc_tready out 1.
REQ-006 usr_m_axis_rc_tdata/tkeep/tlast/tvalid/tuser out, same widths: forwarded stream.
REQ-007 config_mode in 1; icq_full in 1.
REQ-008 req_valid in 1, req_tag in 3: config request issued under tag; req_err out 1: issue rejected.
REQ-009 res_valid out 1; res_tag out 3; res_sc/res_ur/res_crs/res_ca/res_timeout out 1 each; res_data out 32; cpl_mismatch out 1; outstanding out 4: count of busy tags.

Function
REQ-010 rport_m_axis_rc_tready SHALL equal !icq_full; a beat is accepted only when tvalid && tready.
REQ-011 SOP SHALL be an accepted beat with tuser[32]=1.
REQ-012 Check stage SHALL be a pipeline register when EXTRA_PIPELINE=1, the input when 0; usr_* SHALL be registered one cycle after the check stage, with usr tvalid = check tvalid && !config_mode.
REQ-013 Issue: req_valid with req_tag<NUM_TAGS and tag idle SHALL set busy and load that tag's timer with TIMEOUT_CYCLES; busy tag or tag>=NUM_TAGS SHALL pulse req_err for one cycle with no state change.
REQ-014 Check-stage SOP with tdata[30]=1, tdata[87:72]=REQUESTER_ID, tag tdata[71:64]<NUM_TAGS and busy SHALL produce one res_valid pulse one cycle later: res_tag, status one-hot from tdata[45:43] (000 sc, 001 ur, 010 crs, 100 ca; other codes none set), res_data=tdata[127:96] if tkeep[3] else 0; tag cleared.
REQ-015 Any other check-stage SOP with tdata[30]=1 SHALL pulse cpl_mismatch one cycle later with no res_valid and no state change; SOPs with tdata[30]=0 SHALL be ignored.
REQ-016 End-to-end result latency SHALL be 1+EXTRA_PIPELINE cycles from the accepted SOP beat.
REQ-017 Each busy timer SHALL decrement by 1 per cycle, saturating at 0; a busy tag at 0 is expired.
REQ-018 Expired tag SHALL produce res_valid with res_timeout=1, status bits 0, res_data 0, and clear busy.
REQ-019 At most one res_valid per cycle; priority completion > lowest-numbered expired tag; deferred expiries SHALL remain pending and report on later cycles.
REQ-020 Completion and expiry of the same tag in one cycle: completion SHALL win; no timeout reported.
REQ-021 Issue and completion of the same tag in one cycle: completion SHALL use pre-cycle busy state; issue to a tag busy pre-cycle SHALL be rejected.
REQ-022 outstanding SHALL equal the population count of busy bits, registered.
REQ-023 All res_* fields other than res_valid SHALL be 0 in cycles without res_valid.

Reset
REQ-024 reset_n low SHALL asynchronously clear all busy bits, timers, pipeline and usr_* registers, res_*, req_err, cpl_mismatch and outstanding to 0; the first post-deassertion edge performs normal operation.
REQ-025 Reset mid-transaction SHALL discard in-flight beats and pending expiries without reporting them.

Structure
REQ-026 Package pcie_cfg_pkg SHALL hold status codes (SC/UR/CRS/CA), descriptor field bit positions and SOP tuser bit index.
REQ-027 One sub-module pcie_cfg_tag_timer (load, decrement, saturate, expired flag) SHALL be instantiated NUM_TAGS times.

Verification
REQ-028 Issue tag 2, SOP tdata[30]=1, ID 16'h10EE, tag 2, status 000, tkeep[3]=1, data 32'hCAFE0001 -> res_valid 2 cycles later, res_tag 2, res_sc 1, res_data 32'hCAFE0001, outstanding 1->0.
REQ-029 Issue tag 1, no completion, TIMEOUT_CYCLES=16 -> res_timeout with tag 1 after timer reaches 0; outstanding 0.
REQ-030 Completion with ID 16'h1234 for busy tag 0 -> cpl_mismatch pulse, no res_valid, tag 0 still busy.
REQ-031 Tags 0 and 3 expire in the same cycle as a completion for tag 1 -> results in order tag 1, tag 0 (timeout), tag 3 (timeout) on consecutive cycles.
REQ-032 Issue tag 2 twice -> second req_err pulse; icq_full=1 -> tready 0 and SOP not decoded; config_mode=1 -> usr tvalid 0.
REQ-033 reset_n asserted with 3 tags busy -> all outputs 0 immediately, no results after release.
